// File: rtl/id_ctrl_pipe.sv
// Registered RV32 decode stage sitting on the ID/EX boundary.
// Decodes the opcode into the control bundle and registers it behind a valid/ready handshake.
// Also handles load-use hazard bubbles, flush, illegal-opcode flagging and a multi-cycle
// issue hold after M-extension ops.
// Optional feature: define FPU_EN to decode OP-FP, FLW and FSW; otherwise those are illegal.
module id_ctrl_pipe #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [1:0]      out_alu_op,
    output logic [1:0]      out_alu_src_a,
    output logic            out_alu_src_b,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_mem_write,
    output logic            out_mem_read,
    output logic            out_reg_write,
    output logic [1:0]      out_result_src,
    output logic            out_falu_en,
    output logic            out_muldiv,
    output logic            out_illegal,
    output logic            busy
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef FPU_EN
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
`endif

    localparam int unsigned    CNT_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LAT - 1);
    localparam logic             HOLD_EN  = (MULDIV_LAT > 1);

    typedef enum logic {StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;
    logic [1:0] d_alu_op, d_alu_src_a, d_result_src;
    logic       d_alu_src_b, d_branch, d_jal, d_jalr, d_mem_write, d_mem_read, d_reg_write;
    logic       d_falu_en, d_muldiv, d_illegal;
    logic       rs1_used, rs2_used;
    logic       hazard, accept;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    // funct3 plays no part in control decode here
    logic unused_funct3;
    assign unused_funct3 = ^in_instr[14:12];

    // Opcode decode into the control bundle plus register-usage flags for the hazard check
    always_comb begin
        d_alu_op     = 2'd0;
        d_alu_src_a  = 2'd0;
        d_alu_src_b  = 1'b0;
        d_branch     = 1'b0;
        d_jal        = 1'b0;
        d_jalr       = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_reg_write  = 1'b0;
        d_result_src = 2'd0;
        d_falu_en    = 1'b0;
        d_muldiv     = 1'b0;
        d_illegal    = 1'b0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        case (opcode)
            OP_R: begin
                d_alu_op = 2'd2; d_reg_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                d_muldiv = (funct7 == 7'b0000001);
            end
            OP_LOAD: begin
                d_alu_src_b = 1'b1; d_mem_read = 1'b1; d_result_src = 2'd1;
                d_reg_write = 1'b1; rs1_used = 1'b1;
            end
            OP_IMM: begin
                d_alu_op = 2'd3; d_alu_src_b = 1'b1; d_reg_write = 1'b1; rs1_used = 1'b1;
            end
            OP_JALR: begin
                d_alu_src_b = 1'b1; d_jalr = 1'b1; d_result_src = 2'd2;
                d_reg_write = 1'b1; rs1_used = 1'b1;
            end
            OP_STORE: begin
                d_alu_src_b = 1'b1; d_mem_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                d_alu_op = 2'd1; d_branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_AUIPC: begin
                d_alu_src_a = 2'd1; d_alu_src_b = 1'b1; d_reg_write = 1'b1;
            end
            OP_LUI: begin
                d_alu_src_a = 2'd2; d_alu_src_b = 1'b1; d_reg_write = 1'b1;
            end
            OP_JAL: begin
                d_jal = 1'b1; d_result_src = 2'd2; d_reg_write = 1'b1;
            end
`ifdef FPU_EN
            OP_FP: begin
                d_alu_op = 2'd2; d_reg_write = 1'b1; d_falu_en = 1'b1;
            end
            OP_FLW: begin
                d_alu_src_b = 1'b1; d_mem_read = 1'b1; d_result_src = 2'd1;
                d_reg_write = 1'b1; rs1_used = 1'b1;
            end
            OP_FSW: begin
                d_alu_src_b = 1'b1; d_mem_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
`endif
            default: d_illegal = 1'b1;
        endcase
    end

    // Load-use stall and input handshake; flush drops whatever is offered this cycle
    always_comb begin
        hazard = in_valid & ex_mem_read & (ex_rd != 5'd0) &
                 ((rs1_used & (ex_rd == rs1)) | (rs2_used & (ex_rd == rs2)));
        in_ready = (state_q == StRun) & ~hazard & ~flush & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
        busy     = (state_q == StHold);
    end

    // Issue-hold FSM next state: an accepted M-ext op blocks new issue for MULDIV_LAT-1 cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept && d_muldiv && HOLD_EN) begin
                        state_d = StHold;
                        cnt_d   = CNT_INIT;
                    end
                end
                StHold: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and hold counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ID/EX register: load on accept, bubble when drained, hold under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_alu_op     <= '0;
            out_alu_src_a  <= '0;
            out_alu_src_b  <= 1'b0;
            out_branch     <= 1'b0;
            out_jal        <= 1'b0;
            out_jalr       <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_reg_write  <= 1'b0;
            out_result_src <= '0;
            out_falu_en    <= 1'b0;
            out_muldiv     <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_pc         <= in_pc;
            out_rd         <= rd;
            out_rs1        <= rs1;
            out_rs2        <= rs2;
            out_alu_op     <= d_alu_op;
            out_alu_src_a  <= d_alu_src_a;
            out_alu_src_b  <= d_alu_src_b;
            out_branch     <= d_branch;
            out_jal        <= d_jal;
            out_jalr       <= d_jalr;
            out_mem_write  <= d_mem_write;
            out_mem_read   <= d_mem_read;
            out_reg_write  <= d_reg_write;
            out_result_src <= d_result_src;
            out_falu_en    <= d_falu_en;
            out_muldiv     <= d_muldiv;
            out_illegal    <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
